// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory / write-back stage.
// Holds the Mem_To_Reg select encodings and the datapath widths used by the
// control unit, EX/MEM and MEM/WB, plus the MEM/WB register payload.
package mem_wb_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;

    // Write-back source select; 2'b11 is reserved and falls back to the ALU path.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

    // MEM/WB pipeline register payload.
    typedef struct packed {
        logic              reg_write;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] write_data;
        logic [DATA_W-1:0] mem_data;
    } mem_wb_t;

endpackage : mem_wb_stage_pkg

// File: rtl/mem_wb_stage_data_memory.sv
// Single-port data memory: asynchronous read, synchronous gated write.
// Ports:
//   clk   - clock, writes happen on posedge
//   we    - write enable (already qualified by stall/flush/reset/range)
//   addr  - word address
//   wdata - store data
//   rdata - combinational read data at addr (old contents during a write)
module mem_wb_stage_data_memory
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read-before-write falls out naturally: rdata reflects pre-edge contents.
    assign rdata = mem[addr];

endmodule : mem_wb_stage_data_memory

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register.
// Performs the data-memory access for the instruction leaving EX/MEM, selects
// the write-back value (ALU / load data / PC+1) and registers it for the
// register file and forwarding network. Flags out-of-range accesses.
// Ports:
//   clk, rst_n        - clock; synchronous active-low reset
//   Enable            - 1 advance, 0 stall (hold MEM/WB, no store)
//   CLR               - flush: bubble into MEM/WB, no store
//   PC_Adder_In       - PC+1 link value
//   Reg_Write_In      - register write request
//   Mem_Write_In      - store request
//   Mem_Read_In       - load request
//   Mem_To_Reg_In     - write-back select (wb_sel_e)
//   ALU_Result_In     - ALU result / word address
//   Read_Data2_In     - store data
//   Write_Reg_In      - destination register
//   Reg_Write_Out     - registered register write enable
//   Write_Reg_Out     - registered destination register
//   Write_Data_Out    - registered write-back value
//   Mem_Data_Out      - registered raw load data
//   Mem_Fault         - sticky out-of-range access flag
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Enable,
    input  logic              CLR,
    input  logic [DATA_W-1:0] PC_Adder_In,
    input  logic              Reg_Write_In,
    input  logic              Mem_Write_In,
    input  logic              Mem_Read_In,
    input  logic [1:0]        Mem_To_Reg_In,
    input  logic [DATA_W-1:0] ALU_Result_In,
    input  logic [DATA_W-1:0] Read_Data2_In,
    input  logic [REG_W-1:0]  Write_Reg_In,
    output logic              Reg_Write_Out,
    output logic [REG_W-1:0]  Write_Reg_Out,
    output logic [DATA_W-1:0] Write_Data_Out,
    output logic [DATA_W-1:0] Mem_Data_Out,
    output logic              Mem_Fault
);

    logic [ADDR_W-1:0] addr_c;
    logic              in_range_c;
    logic              mem_we_c;
    logic              fault_set_c;
    logic [DATA_W-1:0] ram_rdata_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] wb_data_c;
    mem_wb_t           mem_wb_q;
    mem_wb_t           mem_wb_d_c;
    logic              fault_q;

    // Address decode: upper bits must be zero for an in-range access.
    assign addr_c     = ALU_Result_In[ADDR_W-1:0];
    assign in_range_c = (ALU_Result_In[DATA_W-1:ADDR_W] == '0);

    // Store only when the instruction really advances, so a stall cannot commit twice.
    assign mem_we_c    = Mem_Write_In & Enable & ~CLR & rst_n & in_range_c;
    assign fault_set_c = (Mem_Read_In | Mem_Write_In) & ~in_range_c & Enable & ~CLR;

    mem_wb_stage_data_memory #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .addr  (addr_c),
        .wdata (Read_Data2_In),
        .rdata (ram_rdata_c)
    );

    // Load data is forced to zero when not reading or out of range.
    assign load_data_c = (Mem_Read_In && in_range_c) ? ram_rdata_c : '0;

    // Write-back source select.
    always_comb begin
        wb_data_c = ALU_Result_In;
        case (wb_sel_e'(Mem_To_Reg_In))
            WB_MEM:  wb_data_c = load_data_c;
            WB_PC:   wb_data_c = PC_Adder_In;
            default: wb_data_c = ALU_Result_In;
        endcase
    end

    // MEM/WB next state: flush beats advance, otherwise hold.
    always_comb begin
        mem_wb_d_c = mem_wb_q;
        if (CLR) begin
            mem_wb_d_c = '0;
        end else if (Enable) begin
            mem_wb_d_c.reg_write  = Reg_Write_In;
            mem_wb_d_c.write_reg  = Write_Reg_In;
            mem_wb_d_c.write_data = wb_data_c;
            mem_wb_d_c.mem_data   = load_data_c;
        end
    end

    // MEM/WB register and sticky fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wb_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            mem_wb_q <= mem_wb_d_c;
            fault_q  <= fault_q | fault_set_c;
        end
    end

    assign Reg_Write_Out  = mem_wb_q.reg_write;
    assign Write_Reg_Out  = mem_wb_q.write_reg;
    assign Write_Data_Out = mem_wb_q.write_data;
    assign Mem_Data_Out   = mem_wb_q.mem_data;
    assign Mem_Fault      = fault_q;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (ADDR_W = 8).
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        Enable;
    logic        CLR;
    logic [15:0] PC_Adder_In;
    logic        Reg_Write_In;
    logic        Mem_Write_In;
    logic        Mem_Read_In;
    logic [1:0]  Mem_To_Reg_In;
    logic [15:0] ALU_Result_In;
    logic [15:0] Read_Data2_In;
    logic [2:0]  Write_Reg_In;
    logic        Reg_Write_Out;
    logic [2:0]  Write_Reg_Out;
    logic [15:0] Write_Data_Out;
    logic [15:0] Mem_Data_Out;
    logic        Mem_Fault;

    int checks;
    int failures;

    mem_wb_stage #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Enable         (Enable),
        .CLR            (CLR),
        .PC_Adder_In    (PC_Adder_In),
        .Reg_Write_In   (Reg_Write_In),
        .Mem_Write_In   (Mem_Write_In),
        .Mem_Read_In    (Mem_Read_In),
        .Mem_To_Reg_In  (Mem_To_Reg_In),
        .ALU_Result_In  (ALU_Result_In),
        .Read_Data2_In  (Read_Data2_In),
        .Write_Reg_In   (Write_Reg_In),
        .Reg_Write_Out  (Reg_Write_Out),
        .Write_Reg_Out  (Write_Reg_Out),
        .Write_Data_Out (Write_Data_Out),
        .Mem_Data_Out   (Mem_Data_Out),
        .Mem_Fault      (Mem_Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Reg_Write_In  = 1'b0;
        Mem_Write_In  = 1'b0;
        Mem_Read_In   = 1'b0;
        Mem_To_Reg_In = 2'b00;
        ALU_Result_In = 16'h0000;
        Read_Data2_In = 16'h0000;
        Write_Reg_In  = 3'd0;
        PC_Adder_In   = 16'h0000;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        idle();
        Mem_Write_In  = 1'b1;
        ALU_Result_In = a;
        Read_Data2_In = d;
    endtask

    task automatic load(input logic [15:0] a, input logic [2:0] rd);
        idle();
        Mem_Read_In   = 1'b1;
        Reg_Write_In  = 1'b1;
        Mem_To_Reg_In = 2'b01;
        ALU_Result_In = a;
        Write_Reg_In  = rd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        Enable   = 1'b1;
        CLR      = 1'b0;
        idle();

        // Reset state
        tick();
        check("rst_rw",    16'(Reg_Write_Out), 16'h0);
        check("rst_wr",    16'(Write_Reg_Out), 16'h0);
        check("rst_wd",    Write_Data_Out,     16'h0);
        check("rst_md",    Mem_Data_Out,       16'h0);
        check("rst_fault", 16'(Mem_Fault),     16'h0);
        #1 rst_n = 1'b1;

        // 1. Store then load
        store(16'h0010, 16'hBEEF);
        tick();
        check("sw_rw", 16'(Reg_Write_Out), 16'h0);
        check("sw_wd", Write_Data_Out,     16'h0010);
        load(16'h0010, 3'd3);
        tick();
        check("lw_wd", Write_Data_Out,     16'hBEEF);
        check("lw_wr", 16'(Write_Reg_Out), 16'h3);
        check("lw_rw", 16'(Reg_Write_Out), 16'h1);
        check("lw_md", Mem_Data_Out,       16'hBEEF);

        // 2. JAL, ALU and reserved select
        idle();
        Reg_Write_In  = 1'b1;
        Mem_To_Reg_In = 2'b10;
        PC_Adder_In   = 16'h0042;
        ALU_Result_In = 16'h0099;
        Write_Reg_In  = 3'd7;
        tick();
        check("jal_wd", Write_Data_Out,     16'h0042);
        check("jal_wr", 16'(Write_Reg_Out), 16'h7);
        check("jal_md", Mem_Data_Out,       16'h0);
        Mem_To_Reg_In = 2'b00;
        ALU_Result_In = 16'h1234;
        Write_Reg_In  = 3'd2;
        tick();
        check("alu_wd", Write_Data_Out, 16'h1234);
        Mem_To_Reg_In = 2'b11;
        ALU_Result_In = 16'h0ABC;
        tick();
        check("rsv_wd", Write_Data_Out, 16'h0ABC);

        // 3. Stall with a pending store
        store(16'h0020, 16'h1111);
        Reg_Write_In = 1'b1;
        Write_Reg_In = 3'd5;
        tick();
        check("pre_stall_wd", Write_Data_Out, 16'h0020);
        store(16'h0020, 16'h5555);
        Reg_Write_In  = 1'b1;
        Write_Reg_In  = 3'd6;
        Mem_To_Reg_In = 2'b10;
        PC_Adder_In   = 16'hFFFF;
        Enable        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_wd",  Write_Data_Out,        16'h0020);
            check("stall_wr",  16'(Write_Reg_Out),    16'h5);
            check("stall_ram", dut.u_mem.mem[8'h20], 16'h1111);
        end
        Enable = 1'b1;
        tick();
        check("release_wd",  Write_Data_Out,        16'hFFFF);
        check("release_wr",  16'(Write_Reg_Out),    16'h6);
        check("release_ram", dut.u_mem.mem[8'h20], 16'h5555);
        load(16'h0020, 3'd1);
        tick();
        check("stall_lw", Write_Data_Out, 16'h5555);

        // 4. Flush suppresses the store and bubbles the register
        store(16'h0030, 16'h2222);
        tick();
        store(16'h0030, 16'h9999);
        Reg_Write_In  = 1'b1;
        Write_Reg_In  = 3'd4;
        Mem_To_Reg_In = 2'b10;
        PC_Adder_In   = 16'h7777;
        CLR           = 1'b1;
        tick();
        check("clr_rw", 16'(Reg_Write_Out), 16'h0);
        check("clr_wd", Write_Data_Out,     16'h0);
        check("clr_wr", 16'(Write_Reg_Out), 16'h0);
        CLR = 1'b0;
        load(16'h0030, 3'd1);
        tick();
        check("clr_lw", Write_Data_Out, 16'h2222);

        // Load and store together: store commits, load sees old data
        load(16'h0030, 3'd2);
        Mem_Write_In  = 1'b1;
        Read_Data2_In = 16'h3333;
        tick();
        check("rbw_old", Write_Data_Out, 16'h2222);
        load(16'h0030, 3'd2);
        tick();
        check("rbw_new", Write_Data_Out, 16'h3333);

        // 5. Out-of-range access
        store(16'h0000, 16'hAAAA);
        tick();
        check("inr_fault", 16'(Mem_Fault), 16'h0);
        store(16'h0100, 16'hDEAD);
        tick();
        check("oor_fault", 16'(Mem_Fault), 16'h1);
        load(16'h0000, 3'd1);
        tick();
        check("oor_ram0",  Write_Data_Out,  16'hAAAA);
        check("oor_stick", 16'(Mem_Fault),  16'h1);
        load(16'h0100, 3'd1);
        tick();
        check("oor_lw_wd", Write_Data_Out, 16'h0);
        check("oor_lw_md", Mem_Data_Out,   16'h0);

        // 6. Reset with a pending store and live outputs
        load(16'h0000, 3'd6);
        tick();
        check("pre_rst_wd", Write_Data_Out, 16'hAAAA);
        store(16'h0000, 16'h4444);
        Reg_Write_In = 1'b1;
        rst_n        = 1'b0;
        tick();
        check("rst2_rw",    16'(Reg_Write_Out), 16'h0);
        check("rst2_wr",    16'(Write_Reg_Out), 16'h0);
        check("rst2_wd",    Write_Data_Out,     16'h0);
        check("rst2_md",    Mem_Data_Out,       16'h0);
        check("rst2_fault", 16'(Mem_Fault),     16'h0);
        rst_n = 1'b1;
        load(16'h0000, 3'd1);
        tick();
        check("rst2_ram", Write_Data_Out, 16'hAAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_wb_stage
